instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 157 +++++++++++++++
 tb/tb_instr_decode_stage.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Decode stage: slices a 32-bit MIPS-style word into fields, immediates,
// jump target and class flags, behind a two-entry output/skid buffer.
module instr_decode_stage #(
  parameter int PC_W        = 32,
  parameter int IMM_W       = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            inst_in,
  input  logic [PC_W-1:0]        pc_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             sa,
  output logic [5:0]             func,
  output logic [25:0]            instr_index,
  output logic [PC_W-1:0]        pc_out,
  output logic [IMM_W-1:0]       imm_sext,
  output logic [IMM_W-1:0]       imm_zext,
  output logic [PC_W-1:0]        jump_target,
  output logic                   is_rtype,
  output logic                   is_imm_alu,
  output logic                   is_load,
  output logic                   is_store,
  output logic                   is_branch,
  output logic                   is_jump,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       sa;
    logic [5:0]       func;
    logic [25:0]      instr_index;
    logic [PC_W-1:0]  pc;
    logic [IMM_W-1:0] imm_sext;
    logic [IMM_W-1:0] imm_zext;
    logic [PC_W-1:0]  jump_target;
    logic             is_rtype;
    logic             is_imm_alu;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_jump;
  } dec_t;

  dec_t                   dec_d;
  dec_t                   out_q;
  dec_t                   skid_q;
  logic                   out_v_q;
  logic                   skid_v_q;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [PC_W-1:0]        pc_plus4;
  logic [5:0]             op;
  logic                   accept;
  logic                   consume;
  logic                   stalled;

  assign op       = inst_in[31:26];
  assign pc_plus4 = pc_in + PC_W'(4);

  always_comb begin
    dec_d             = '0;
    dec_d.opcode      = op;
    dec_d.rs          = inst_in[25:21];
    dec_d.rt          = inst_in[20:16];
    dec_d.rd          = inst_in[15:11];
    dec_d.sa          = inst_in[10:6];
    dec_d.func        = inst_in[5:0];
    dec_d.instr_index = inst_in[25:0];
    dec_d.pc          = pc_in;
    dec_d.imm_sext    = IMM_W'($signed(inst_in[15:0]));
    dec_d.imm_zext    = IMM_W'(inst_in[15:0]);
    dec_d.jump_target = {pc_plus4[PC_W-1:28], inst_in[25:0], 2'b00};
    unique case (1'b1)
      (op == 6'b000000):      dec_d.is_rtype   = 1'b1;
      (op[5:1] == 5'b00001):  dec_d.is_jump    = 1'b1;
      (op == 6'b000001),
      (op[5:2] == 4'b0001):   dec_d.is_branch  = 1'b1;
      (op[5:3] == 3'b001):    dec_d.is_imm_alu = 1'b1;
      (op[5:3] == 3'b100):    dec_d.is_load    = 1'b1;
      (op[5:3] == 3'b101):    dec_d.is_store   = 1'b1;
      default: ;
    endcase
  end

  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;
  assign consume  = out_v_q & out_ready;
  assign stalled  = out_v_q & ~out_ready;

  // SKID only fills while OUT is held, so it always drains into OUT first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (flush) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (!out_v_q || consume) begin
      if (skid_v_q) begin
        out_q    <= skid_q;
        out_v_q  <= 1'b1;
        skid_v_q <= 1'b0;
      end else if (accept) begin
        out_q   <= dec_d;
        out_v_q <= 1'b1;
      end else begin
        out_v_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec_d;
      skid_v_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stalled && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid   = out_v_q;
  assign opcode      = out_q.opcode;
  assign rs          = out_q.rs;
  assign rt          = out_q.rt;
  assign rd          = out_q.rd;
  assign sa          = out_q.sa;
  assign func        = out_q.func;
  assign instr_index = out_q.instr_index;
  assign pc_out      = out_q.pc;
  assign imm_sext    = out_q.imm_sext;
  assign imm_zext    = out_q.imm_zext;
  assign jump_target = out_q.jump_target;
  assign is_rtype    = out_q.is_rtype;
  assign is_imm_alu  = out_q.is_imm_alu;
  assign is_load     = out_q.is_load;
  assign is_store    = out_q.is_store;
  assign is_branch   = out_q.is_branch;
  assign is_jump     = out_q.is_jump;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: queue scoreboard of decoded results,
// directed vectors, backpressure, flush, saturation and reset cases.
module tb_instr_decode_stage;

  localparam int PC_W = 32;
  localparam int IMM_W = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [25:0] idx;
    logic [31:0] pc;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [31:0] jt;
    logic [5:0]  flags;
  } exp_t;

  logic clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst_in, pc_in, pc_out, imm_sext, imm_zext, jump_target;
  logic [5:0] opcode, func;
  logic [4:0] rs, rt, rd, sa;
  logic [25:0] instr_index;
  logic is_rtype, is_imm_alu, is_load, is_store, is_branch, is_jump;
  logic [SW-1:0] stall_cnt;

  exp_t obs;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  instr_decode_stage #(
    .PC_W(PC_W), .IMM_W(IMM_W), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
    .func(func), .instr_index(instr_index), .pc_out(pc_out),
    .imm_sext(imm_sext), .imm_zext(imm_zext),
    .jump_target(jump_target),
    .is_rtype(is_rtype), .is_imm_alu(is_imm_alu),
    .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jump(is_jump),
    .stall_cnt(stall_cnt)
  );

  assign obs = {opcode, rs, rt, rd, sa, func, instr_index,
                pc_out, imm_sext, imm_zext, jump_target,
                is_rtype, is_imm_alu, is_load, is_store,
                is_branch, is_jump};

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i,
                                 input logic [31:0] p);
    exp_t m;
    logic [31:0] p4;
    p4 = p + 32'd4;
    m.opcode = i[31:26];
    m.rs = i[25:21];
    m.rt = i[20:16];
    m.rd = i[15:11];
    m.sa = i[10:6];
    m.func = i[5:0];
    m.idx = i[25:0];
    m.pc = p;
    m.sext = {{16{i[15]}}, i[15:0]};
    m.zext = {16'h0000, i[15:0]};
    m.jt = {p4[31:28], i[25:0], 2'b00};
    casez (i[31:26])
      6'b000000: m.flags = 6'b100000;
      6'b00001?: m.flags = 6'b000001;
      6'b000001: m.flags = 6'b000010;
      6'b0001??: m.flags = 6'b000010;
      6'b001???: m.flags = 6'b010000;
      6'b100???: m.flags = 6'b001000;
      6'b101???: m.flags = 6'b000100;
      default:   m.flags = 6'b000000;
    endcase
    return m;
  endfunction

  // advance one cycle, keeping the scoreboard in step with handshakes
  task automatic tick();
    logic acc, cons;
    acc = in_valid && in_ready;
    cons = out_valid && out_ready;
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (cons && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back(model(inst_in, pc_in));
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    inst_in = i;
    pc_in = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    tests++;
    if (stall_cnt !== '0) begin
      fails++;
      $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
    end
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_data got %h want 0", obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(32'h012A4020, 32'h00400000);
    tests++;
    if (!out_valid || sb.size() != 1 || obs !== sb[0]) begin
      fails++;
      $display("FAIL add_scoreboard got v=%b %h", out_valid, obs);
    end
    tests++;
    if ({rs, rt, rd, sa, func, is_rtype, pc_out} !==
        {5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 1'b1, 32'h00400000}) begin
      fails++;
      $display("FAIL add_fields got rs=%0d rt=%0d rd=%0d sa=%0d f=%h r=%b pc=%h want 9 10 8 0 20 1 00400000",
               rs, rt, rd, sa, func, is_rtype, pc_out);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL add_drain got v=%b q=%0d want 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    send(32'h8D28FFFC, 32'h00400004);
    tests++;
    if ({opcode, rs, rt, is_load, imm_sext, imm_zext} !==
        {6'h23, 5'd9, 5'd8, 1'b1, 32'hFFFFFFFC, 32'h0000FFFC}) begin
      fails++;
      $display("FAIL lw_fields got op=%h rs=%0d rt=%0d ld=%b s=%h z=%h want 23 9 8 1 fffffffc 0000fffc",
               opcode, rs, rt, is_load, imm_sext, imm_zext);
    end
    tests++;
    if (sb.size() != 1 || obs !== sb[0]) begin
      fails++;
      $display("FAIL lw_scoreboard got %h", obs);
    end
    tick();
  endtask

  task automatic test_jump();
    out_ready = 1'b1;
    send(32'h08000010, 32'h40000000);
    tests++;
    if ({is_jump, jump_target} !== {1'b1, 32'h40000040}) begin
      fails++;
      $display("FAIL jump_target got j=%b t=%h want 1 40000040", is_jump, jump_target);
    end
    send(32'h08000010, 32'hFFFFFFFC);
    tests++;
    if ({is_jump, jump_target} !== {1'b1, 32'h00000040}) begin
      fails++;
      $display("FAIL jump_wrap got j=%b t=%h want 1 00000040", is_jump, jump_target);
    end
    tick();
  endtask

  task automatic test_classes();
    logic [5:0] ops [8];
    ops = '{6'h01, 6'h04, 6'h07, 6'h03, 6'h0F, 6'h20, 6'h2B, 6'h3F};
    out_ready = 1'b1;
    foreach (ops[k]) begin
      send({ops[k], 26'h1234567}, 32'h00001000 + 32'(k * 4));
      tests++;
      if (!out_valid || sb.size() != 1 || obs !== sb[0]) begin
        fails++;
        $display("FAIL class_op%h got %h", ops[k], obs);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t a, b;
    a = model(32'h2108FFFF, 32'h00000100);
    b = model(32'hAD09_0004, 32'h00000104);
    do_reset();
    out_ready = 1'b0;
    send(32'h2108FFFF, 32'h00000100);
    in_valid = 1'b1;
    inst_in = 32'hAD090004;
    pc_in = 32'h00000104;
    tick();
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || obs !== a || stall_cnt !== 4'd1) begin
      fails++;
      $display("FAIL bp_full got rdy=%b cnt=%0d obs=%h want 0 1 %h", in_ready, stall_cnt, obs, a);
    end
    tick();
    tick();
    tests++;
    if (obs !== a || !out_valid || stall_cnt !== 4'd3) begin
      fails++;
      $display("FAIL bp_hold got cnt=%0d obs=%h want 3 %h", stall_cnt, obs, a);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (!out_valid || obs !== b || in_ready !== 1'b1 || sb.size() != 1) begin
      fails++;
      $display("FAIL bp_second got v=%b rdy=%b obs=%h want 1 1 %h", out_valid, in_ready, obs, b);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || sb.size() != 0 || stall_cnt !== 4'd3) begin
      fails++;
      $display("FAIL bp_drain got v=%b q=%0d cnt=%0d want 0 0 3", out_valid, sb.size(), stall_cnt);
    end
  endtask

  task automatic test_flush();
    exp_t a;
    logic seen;
    a = model(32'h3C01DEAD, 32'h00000200);
    out_ready = 1'b0;
    send(32'h3C01DEAD, 32'h00000200);
    send(32'h10220008, 32'h00000204);
    in_valid = 1'b1;
    inst_in = 32'h8C430010;
    pc_in = 32'h00000208;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_clear got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    tests++;
    if (obs !== a) begin
      fails++;
      $display("FAIL flush_hold_data got %h want %h", obs, a);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= out_valid;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_emit got %b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic stalled_prev;
    exp_t prev;
    stalled_prev = 1'b0;
    prev = '0;
    for (int c = 0; c < 200; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      inst_in = $urandom;
      pc_in = $urandom & 32'hFFFFFFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra cyc %0d got %h want none", c, obs);
        end else if (obs !== sb[0]) begin
          fails++;
          $display("FAIL b2b_order cyc %0d got %h want %h", c, obs, sb[0]);
        end
      end
      if (stalled_prev) begin
        tests++;
        if (!out_valid || obs !== prev) begin
          fails++;
          $display("FAIL b2b_stable cyc %0d got %h want %h", c, obs, prev);
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev = obs;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && out_valid; c++) tick();
    tests++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain got v=%b q=%0d want 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    out_ready = 1'b0;
    send(32'h24420001, 32'h00000300);
    repeat (5) tick();
    tests++;
    if (stall_cnt !== 4'd5) begin
      fails++;
      $display("FAIL stall_count got %0d want 5", stall_cnt);
    end
    repeat (16) tick();
    tests++;
    if (stall_cnt !== 4'hF || !out_valid) begin
      fails++;
      $display("FAIL stall_sat got %0d want 15", stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid got v=%b cnt=%0d rdy=%b want 0 0 1", out_valid, stall_cnt, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h0C100000, 32'h00400010);
    tests++;
    if (!out_valid || sb.size() != 1 || obs !== sb[0]) begin
      fails++;
      $display("FAIL post_reset_accept got v=%b %h", out_valid, obs);
    end
    tick();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    inst_in = '0;
    pc_in = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_jump();
    test_classes();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_stall_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
